// File: rtl/datapath_seq.sv
// Self-sequencing register-file/shifter/ALU datapath: read A, read B, execute, write back.
// Define DP_CARRY_EN to add a carry flag as status_out[3].
module datapath_seq #(
    parameter int W    = 16,
    parameter int NREG = 8,
    parameter int IMMW = 5,
    localparam int RW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [RW-1:0]   op_rd,
    input  logic [RW-1:0]   op_rn,
    input  logic [RW-1:0]   op_rm,
    input  logic [1:0]      op_alu,
    input  logic [1:0]      op_shift,
    input  logic            op_asel,
    input  logic            op_bsel,
    input  logic [IMMW-1:0] op_imm,
    input  logic [1:0]      op_vsel,
    input  logic            op_write,
    input  logic            op_loads,
    input  logic [W-1:0]    mdata,
    input  logic [W-1:0]    sximm8,
    input  logic [W-1:0]    pc,
    output logic            done,
    output logic [W-1:0]    c,
`ifdef DP_CARRY_EN
    output logic [3:0]      status_out,
`else
    output logic [2:0]      status_out,
`endif
    input  logic [RW-1:0]   dbg_addr,
    output logic [W-1:0]    dbg_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RDA  = 3'd1;
    localparam logic [2:0] S_RDB  = 3'd2;
    localparam logic [2:0] S_EXE  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    typedef struct packed {
        logic [RW-1:0]   rd;
        logic [RW-1:0]   rn;
        logic [RW-1:0]   rm;
        logic [1:0]      alu;
        logic [1:0]      shift;
        logic            asel;
        logic            bsel;
        logic [IMMW-1:0] imm;
        logic [1:0]      vsel;
        logic            write;
        logic            loads;
    } instr_t;

    logic [2:0]   state;
    instr_t       ir;
    logic [W-1:0] regs [NREG];
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] c_q;
    logic         z_q;
    logic         n_q;
    logic         v_q;

    logic [W-1:0] b_sh;
    logic [W-1:0] imm_x;
    logic [W-1:0] ain;
    logic [W-1:0] bin;
    logic [W-1:0] bop;
    logic [W-1:0] sum;
    logic [W-1:0] res;
    logic         is_sub;
    logic         arith;
    logic         v_f;
    logic [W-1:0] wb_data;

    assign req_ready = (state == S_IDLE);
    assign c         = c_q;
    assign dbg_data  = regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ir    <= '0;
            done  <= 1'b0;
        end else begin
            done <= (state == S_EXE);
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        ir    <= '{op_rd, op_rn, op_rm, op_alu, op_shift,
                                   op_asel, op_bsel, op_imm, op_vsel,
                                   op_write, op_loads};
                        state <= S_RDA;
                    end
                end
                S_RDA:   state <= S_RDB;
                S_RDB:   state <= S_EXE;
                S_EXE:   state <= S_WB;
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        b_sh = b_q;
        case (ir.shift)
            2'b01:   b_sh = {b_q[W-2:0], 1'b0};
            2'b10:   b_sh = {1'b0, b_q[W-1:1]};
            2'b11:   b_sh = {b_q[W-1], b_q[W-1:1]};
            default: b_sh = b_q;
        endcase
    end

    assign imm_x  = {{(W-IMMW){ir.imm[IMMW-1]}}, ir.imm};
    assign ain    = ir.asel ? '0 : a_q;
    assign bin    = ir.bsel ? imm_x : b_sh;
    assign is_sub = (ir.alu == 2'b01);
    assign arith  = ~ir.alu[1];
    // SUB is A + ~B + 1, so one adder serves both and its carry is not-borrow
    assign bop    = is_sub ? ~bin : bin;

`ifdef DP_CARRY_EN
    logic [W:0] sum_x;
    logic       cy_q;
    assign sum_x = {1'b0, ain} + {1'b0, bop} + {{W{1'b0}}, is_sub};
    assign sum   = sum_x[W-1:0];
`else
    assign sum   = ain + bop + {{(W-1){1'b0}}, is_sub};
`endif

    assign v_f = arith && (ain[W-1] == bop[W-1]) && (sum[W-1] != ain[W-1]);

    always_comb begin
        res = sum;
        unique case (1'b1)
            (ir.alu == 2'b10): res = ain & bin;
            (ir.alu == 2'b11): res = ~bin;
            arith:             res = sum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            if (state == S_RDA) a_q <= regs[ir.rn];
            if (state == S_RDB) b_q <= regs[ir.rm];
            if (state == S_EXE) begin
                c_q <= res;
                if (ir.loads) begin
                    z_q <= (res == '0);
                    n_q <= res[W-1];
                    v_q <= v_f;
                end
            end
        end
    end

`ifdef DP_CARRY_EN
    // carry only moves on arithmetic ops; logic ops keep the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cy_q <= 1'b0;
        end else if (state == S_EXE && ir.loads && arith) begin
            cy_q <= sum_x[W];
        end
    end
    assign status_out = {cy_q, v_q, n_q, z_q};
`else
    assign status_out = {v_q, n_q, z_q};
`endif

    always_comb begin
        wb_data = c_q;
        case (ir.vsel)
            2'b01:   wb_data = pc;
            2'b10:   wb_data = sximm8;
            2'b11:   wb_data = mdata;
            default: wb_data = c_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (state == S_WB && ir.write) begin
            regs[ir.rd] <= wb_data;
        end
    end

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: default 16-bit build plus a 32-bit/16-register instance.
module tb_datapath_seq;

`ifdef DP_CARRY_EN
    localparam int SW = 4;
`else
    localparam int SW = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    op_rd = '0, op_rn = '0, op_rm = '0;
    logic [1:0]    op_alu = '0, op_shift = '0, op_vsel = '0;
    logic          op_asel = 1'b0, op_bsel = 1'b0, op_write = 1'b0, op_loads = 1'b0;
    logic [4:0]    op_imm = '0;
    logic [15:0]   mdata = '0, sximm8 = '0, pc = '0;
    logic          done;
    logic [15:0]   c;
    logic [SW-1:0] status_out;
    logic [2:0]    dbg_addr = '0;
    logic [15:0]   dbg_data;

    logic          valid32 = 1'b0;
    logic          ready32;
    logic [3:0]    rd32 = '0, rn32 = '0, rm32 = '0;
    logic [1:0]    shift32 = '0, vsel32 = '0;
    logic          asel32 = 1'b0, write32 = 1'b0, loads32 = 1'b0;
    logic [31:0]   mdata32 = '0;
    logic          done32;
    logic [31:0]   c32;
    logic [SW-1:0] status32;
    logic [3:0]    dbg_addr32 = '0;
    logic [31:0]   dbg_data32;

    int n_chk = 0;
    int n_err = 0;

    datapath_seq u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .op_rd(op_rd), .op_rn(op_rn), .op_rm(op_rm),
        .op_alu(op_alu), .op_shift(op_shift),
        .op_asel(op_asel), .op_bsel(op_bsel), .op_imm(op_imm),
        .op_vsel(op_vsel), .op_write(op_write), .op_loads(op_loads),
        .mdata(mdata), .sximm8(sximm8), .pc(pc),
        .done(done), .c(c), .status_out(status_out),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    datapath_seq #(.W(32), .NREG(16), .IMMW(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid32), .req_ready(ready32),
        .op_rd(rd32), .op_rn(rn32), .op_rm(rm32),
        .op_alu(2'b00), .op_shift(shift32),
        .op_asel(asel32), .op_bsel(1'b0), .op_imm(8'h00),
        .op_vsel(vsel32), .op_write(write32), .op_loads(loads32),
        .mdata(mdata32), .sximm8(32'h0), .pc(32'h0),
        .done(done32), .c(c32), .status_out(status32),
        .dbg_addr(dbg_addr32), .dbg_data(dbg_data32)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic [2:0] rd, rn, rm,
                          input logic [1:0] alu, sh,
                          input logic asel, bsel, input logic [4:0] imm,
                          input logic [1:0] vsel, input logic wr, ls);
        op_rd = rd; op_rn = rn; op_rm = rm;
        op_alu = alu; op_shift = sh;
        op_asel = asel; op_bsel = bsel; op_imm = imm;
        op_vsel = vsel; op_write = wr; op_loads = ls;
    endtask

    task automatic issue(input logic [2:0] rd, rn, rm,
                         input logic [1:0] alu, sh,
                         input logic asel, bsel, input logic [4:0] imm,
                         input logic [1:0] vsel, input logic wr, ls);
        int n;
        @(negedge clk);
        set_op(rd, rn, rm, alu, sh, asel, bsel, imm, vsel, wr, ls);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!done && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check("done_lat", n, 3);
        @(posedge clk);
        #1;
    endtask

    task automatic load_imm(input logic [2:0] rd, input logic [15:0] v);
        sximm8 = v;
        issue(rd, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 2'b10, 1'b1, 1'b0);
    endtask

    task automatic chk_reg(input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1 check($sformatf("R%0d", a), dbg_data, exp);
    endtask

    task automatic run32(input logic [3:0] rd, rm, input logic [1:0] sh,
                         input logic asel, input logic [1:0] vsel,
                         input logic wr, ls);
        int n;
        @(negedge clk);
        rd32 = rd; rn32 = 4'd0; rm32 = rm; shift32 = sh;
        asel32 = asel; vsel32 = vsel; write32 = wr; loads32 = ls;
        valid32 = 1'b1;
        @(posedge clk);
        #1 valid32 = 1'b0;
        n = 0;
        while (!done32 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check("done32_lat", n, 3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, first, second, dones;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst_ready", req_ready, 1);

        // seed C, status and R1 so the reset below has something to clear
        sximm8 = 16'h0055;
        issue(3'd1, 3'd0, 3'd0, 2'b00, 2'b00, 1'b1, 1'b1, 5'h1F, 2'b10, 1'b1, 1'b1);
        check("seed_c", c, 16'hFFFF);
        check("seed_st", status_out[2:0], 3'b010);
        chk_reg(3'd1, 16'h0055);

        // abort a pending R2 write in its EXE cycle
        @(negedge clk);
        sximm8 = 16'h1234;
        set_op(3'd2, 3'd1, 3'd1, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 2'b10, 1'b1, 1'b1);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #2 check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dones += int'(done);
        end
        check("rst_nodone", dones, 0);
        check("rst_c", c, 0);
        check("rst_st", status_out, 0);
        check("rst_ready2", req_ready, 1);
        for (int r = 0; r < 8; r++) chk_reg(3'(r), 16'h0000);

        load_imm(3'd0, 16'h0007);
        load_imm(3'd1, 16'h0002);
        issue(3'd2, 3'd0, 3'd1, 2'b00, 2'b01, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1, 1'b1);
        chk_reg(3'd2, 16'h000B);
        check("add_c", c, 16'h000B);
        check("add_st", status_out[2:0], 3'b000);

        load_imm(3'd4, 16'h7FFF);
        load_imm(3'd5, 16'hFFFF);
        issue(3'd6, 3'd4, 3'd5, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1, 1'b1);
        check("sub_ov_c", c, 16'h8000);
        check("sub_ov_st", status_out[2:0], 3'b110);
        chk_reg(3'd6, 16'h8000);

        issue(3'd7, 3'd2, 3'd2, 2'b01, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1, 1'b1);
        check("sub_z_c", c, 16'h0000);
        check("sub_z_st", status_out[2:0], 3'b001);

        load_imm(3'd3, 16'h00FF);
        issue(3'd7, 3'd0, 3'd3, 2'b11, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1, 1'b1);
        check("mvn_c", c, 16'hFF00);
        check("mvn_st", status_out[2:0], 3'b010);
        chk_reg(3'd7, 16'hFF00);

        // negative immediate with A forced to zero; status must not move
        issue(3'd0, 3'd6, 3'd6, 2'b00, 2'b00, 1'b1, 1'b1, 5'b10000, 2'b00, 1'b0, 1'b0);
        check("imm_c", c, 16'hFFF0);
        check("noload_st", status_out[2:0], 3'b010);

`ifdef DP_CARRY_EN
        issue(3'd0, 3'd5, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd1, 2'b00, 1'b0, 1'b1);
        check("carry_c", c, 16'h0000);
        check("carry_st", status_out, 4'b1001);
`endif

        // req_valid held high: accepts every 5 cycles
        set_op(3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0);
        req_valid = 1'b1;
        acc = 0; first = -1; second = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                if (acc == 0) first = i;
                if (acc == 1) second = i;
                acc++;
            end
        end
        req_valid = 1'b0;
        check("hold_acc", acc, 4);
        check("hold_gap", second - first, 5);
        @(posedge clk);
        #1;

        // busy-time pulses must not start a second instruction
        pc = 16'h1111;
        @(negedge clk);
        set_op(3'd6, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 2'b01, 1'b1, 1'b0);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dones += int'(done);
            req_valid = (i <= 3) && (i != 1);
        end
        check("drop_dones", dones, 1);
        chk_reg(3'd6, 16'h1111);

        load_imm(3'd2, 16'h0021);
        issue(3'd3, 3'd2, 3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1, 1'b1);
        chk_reg(3'd3, 16'h0042);
        issue(3'd3, 3'd3, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1, 1'b1);
        chk_reg(3'd3, 16'h0084);

        mdata32 = 32'h8000_0000;
        run32(4'd15, 4'd0, 2'b00, 1'b0, 2'b11, 1'b1, 1'b0);
        run32(4'd14, 4'd15, 2'b11, 1'b1, 2'b00, 1'b1, 1'b1);
        check("asr32_c", c32, 32'hC000_0000);
        check("asr32_st", 32'(status32[2:0]), 32'd2);
        dbg_addr32 = 4'd14;
        #1 check("R14_32", dbg_data32, 32'hC000_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
